serial_pattern_tx: RTL and testbench

- Bit-serial transmitter that drives the stream feeding the 1011 Mealy sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock.
- Emits a registered golden flag, exp_match, that marks every bit completing an overlapping 1011 pattern, and keeps a saturating match count.
- Sits upstream of the detector as the stimulus source and scoreboard reference.

---
 rtl/serial_pattern_tx_if.sv | 22 ++
 rtl/serial_pattern_tx.sv | 106 ++++++++++
 tb/tb_serial_pattern_tx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_tx_if.sv
// Parallel-load handshake plus the serial stream it produces.
// The master loads words and observes the stream; the slave is the transmitter.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             dout;
  logic             dout_valid;
  logic             last;

  modport master (
    output load_data, load_valid,
    input  load_ready, dout, dout_valid, last
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, dout, dout_valid, last
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// MSB-first serialiser feeding a 1011 detector, with a registered golden
// overlapping-1011 match flag and a saturating match counter.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_pattern_tx_if.slave   bus,
  output logic                 exp_match,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 busy
);

  localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]       hist_q, hist_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             last_q, last_d;
  logic             exp_match_q, exp_match_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             load_ready;
  logic             accept;
  logic             nb;

  // bit_cnt counts bits still to send after the one going out next edge,
  // so a new word can be taken on the same edge that sends the LSB
  assign load_ready = (state_q == IDLE) || (bit_cnt_q == '0);
  assign accept     = bus.load_valid && load_ready;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    nb           = 1'b0;
    dout_valid_d = 1'b0;
    last_d       = 1'b0;

    if (state_q == SHIFT) begin
      nb           = shift_q[WIDTH-1];
      dout_valid_d = 1'b1;
      last_d       = (bit_cnt_q == '0);
      shift_d      = shift_q << 1;
      if (bit_cnt_q == '0) begin
        state_d = IDLE;
      end else begin
        bit_cnt_d = bit_cnt_q - BC_W'(1);
      end
    end

    if (accept) begin
      shift_d   = bus.load_data;
      bit_cnt_d = LAST_IDX;
      state_d   = SHIFT;
    end

    // idle cycles shift a 0 into the history, matching the detector's view
    dout_d      = nb;
    exp_match_d = (hist_q == 3'b101) && nb;
    hist_d      = {hist_q[1:0], nb};
    match_cnt_d = match_cnt_q;
    if (exp_match_d && (match_cnt_q != '1)) begin
      match_cnt_d = match_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      hist_q       <= 3'b000;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      last_q       <= 1'b0;
      exp_match_q  <= 1'b0;
      match_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      hist_q       <= hist_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      last_q       <= last_d;
      exp_match_q  <= exp_match_d;
      match_cnt_q  <= match_cnt_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.last       = last_q;
  assign exp_match      = exp_match_q;
  assign match_cnt      = match_cnt_q;
  assign busy           = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: table of word sequences with
// hand-computed match positions, plus mid-word reset and saturation cases.
module tb_serial_pattern_tx;

  logic clk;
  logic rst_n;
  logic rst2_n;

  serial_pattern_tx_if #(.WIDTH(8)) bus1 ();
  serial_pattern_tx_if #(.WIDTH(8)) bus2 ();

  logic       exp_match1, busy1;
  logic [7:0] match_cnt1;
  logic       exp_match2, busy2;
  logic [1:0] match_cnt2;

  serial_pattern_tx #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(rst_n), .bus(bus1),
    .exp_match(exp_match1), .match_cnt(match_cnt1), .busy(busy1)
  );

  serial_pattern_tx #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(rst2_n), .bus(bus2),
    .exp_match(exp_match2), .match_cnt(match_cnt2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got=running required=done");
    $fatal(1, "timeout");
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input int v, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec=%0d cyc=%0d got=%0h required=%0h", nm, v, i, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rst2_n = 1'b0;
    bus1.load_valid = 1'b0;
    bus1.load_data  = '0;
    bus2.load_valid = 1'b0;
    bus2.load_data  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rst2_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  w0;
    logic [7:0]  w1;
    int          nwords;
    int          gap;
    logic [23:0] match_at;  // bit i set: exp_match after accept-relative edge i
    int          exp_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] w;
    int s0, s1, run_cnt, horizon;
    logic e_dv, e_dout, e_last, e_busy, e_rdy, e_m;

    vecs[0] = '{8'b1011_0000, 8'h00,        1, 0, 24'h000010, 1};
    vecs[1] = '{8'b1011_0110, 8'h00,        1, 0, 24'h000090, 2};
    vecs[2] = '{8'b0000_0101, 8'b1000_0000, 2, 0, 24'h000200, 1};
    vecs[3] = '{8'b0000_0101, 8'b1000_0000, 2, 1, 24'h000000, 0};
    vecs[4] = '{8'b1011_1011, 8'h00,        1, 0, 24'h000110, 2};
    vecs[5] = '{8'hFF,        8'h00,        1, 0, 24'h000000, 0};

    horizon = 20;
    for (int v = 0; v < 6; v++) begin
      do_reset();
      check("rst_ready", v, -1, 32'(bus1.load_ready), 32'd1);
      check("rst_dv",    v, -1, 32'(bus1.dout_valid), 32'd0);
      check("rst_busy",  v, -1, 32'(busy1), 32'd0);
      check("rst_cnt",   v, -1, 32'(match_cnt1), 32'd0);

      bus1.load_data  = vecs[v].w0;
      bus1.load_valid = 1'b1;
      @(posedge clk);
      s0 = 0;
      s1 = 8 + vecs[v].gap;
      run_cnt = 0;
      for (int i = 0; i < horizon; i++) begin
        @(negedge clk);
        e_dv = 1'b0; e_dout = 1'b0; e_last = 1'b0;
        e_busy = (i >= s0 && i <= s0 + 7);
        e_rdy  = !(i >= s0 && i <= s0 + 6);
        if (i >= s0 + 1 && i <= s0 + 8) begin
          w = vecs[v].w0;
          e_dv = 1'b1;
          e_dout = w[7 - (i - s0 - 1)];
          e_last = (i == s0 + 8);
        end
        if (vecs[v].nwords == 2) begin
          if (i >= s1 && i <= s1 + 7) e_busy = 1'b1;
          if (i >= s1 && i <= s1 + 6) e_rdy = 1'b0;
          if (i >= s1 + 1 && i <= s1 + 8) begin
            w = vecs[v].w1;
            e_dv = 1'b1;
            e_dout = w[7 - (i - s1 - 1)];
            e_last = (i == s1 + 8);
          end
        end
        e_m = vecs[v].match_at[i];
        if (e_m) run_cnt++;
        check("dout",       v, i, 32'(bus1.dout), 32'(e_dout));
        check("dout_valid", v, i, 32'(bus1.dout_valid), 32'(e_dv));
        check("last",       v, i, 32'(bus1.last), 32'(e_last));
        check("busy",       v, i, 32'(busy1), 32'(e_busy));
        check("load_ready", v, i, 32'(bus1.load_ready), 32'(e_rdy));
        check("exp_match",  v, i, 32'(exp_match1), 32'(e_m));
        check("match_cnt",  v, i, 32'(match_cnt1), 32'(run_cnt));

        if (vecs[v].nwords == 2 && vecs[v].gap == 0) begin
          if (i == 0) bus1.load_data = vecs[v].w1;
          if (i == 8) bus1.load_valid = 1'b0;
        end else begin
          if (i == 0) bus1.load_valid = 1'b0;
          if (vecs[v].nwords == 2 && i == 8) begin
            bus1.load_data  = vecs[v].w1;
            bus1.load_valid = 1'b1;
          end
          if (i == 9) bus1.load_valid = 1'b0;
        end
      end
      check("final_cnt", v, horizon, 32'(match_cnt1), 32'(vecs[v].exp_cnt));
      $display("[TB] vector %0d: w0=%b w1=%b words=%0d gap=%0d final match_cnt=%0d",
               v, vecs[v].w0, vecs[v].w1, vecs[v].nwords, vecs[v].gap, match_cnt1);
    end

    // Reset asserted mid-word, away from any clock edge
    do_reset();
    bus1.load_data  = 8'b1011_1111;
    bus1.load_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.load_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_dout", 10, 5, 32'(bus1.dout), 32'd1);
    check("pre_rst_cnt",  10, 5, 32'(match_cnt1), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_dout",  10, 5, 32'(bus1.dout), 32'd0);
    check("arst_dv",    10, 5, 32'(bus1.dout_valid), 32'd0);
    check("arst_busy",  10, 5, 32'(busy1), 32'd0);
    check("arst_cnt",   10, 5, 32'(match_cnt1), 32'd0);
    check("arst_ready", 10, 5, 32'(bus1.load_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_ready", 10, 6, 32'(bus1.load_ready), 32'd1);
    bus1.load_data  = 8'b1011_0000;
    bus1.load_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.load_valid = 1'b0;
    w = 8'b1011_0000;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("rel_dout",  10, i, 32'(bus1.dout), 32'(w[8 - i]));
      check("rel_dv",    10, i, 32'(bus1.dout_valid), 32'd1);
      check("rel_match", 10, i, 32'(exp_match1), 32'(i == 4));
    end
    check("rel_cnt", 10, 9, 32'(match_cnt1), 32'd1);
    $display("[TB] mid-word reset: match_cnt after restart=%0d", match_cnt1);

    // Saturation with a 2-bit counter: matches at bits 4, 8, 12, 16
    do_reset();
    bus2.load_data  = 8'b1011_1011;
    bus2.load_valid = 1'b1;
    @(posedge clk);
    run_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      e_m = (i == 4) || (i == 8) || (i == 12) || (i == 16);
      if (e_m && run_cnt < 3) run_cnt++;
      check("sat_match", 11, i, 32'(exp_match2), 32'(e_m));
      check("sat_cnt",   11, i, 32'(match_cnt2), 32'(run_cnt));
      if (i == 8) bus2.load_valid = 1'b0;
    end
    $display("[TB] saturation: match_cnt=%0d", match_cnt2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
